mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter sharing the single physical memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Sits between the IFU/LSU and the memory access module, which drives the DPI pmem read/write calls.
- Carries one transaction at a time and grants with round-robin fairness.
- Registers the payload, sequences the memory handshake, steers the response back to the winner, and flags memory responses that exceed a timeout.

Parameters:
ADDR_WIDTH, 32, address width on all ports
DATA_WIDTH, 32, data width on all ports
TIMEOUT, 255, max cycles in WAIT before error; 0 disables the check

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous active-high reset
ifu_req_valid  input  1  IFU read request
ifu_req_ready  output  1  IFU request accepted this cycle
ifu_raddr  input  ADDR_WIDTH  IFU read address
ifu_resp_valid  output  1  one-cycle pulse, ifu_rdata valid
ifu_rdata  output  DATA_WIDTH  IFU read data
lsu_req_valid  input  1  LSU request
lsu_req_ready  output  1  LSU request accepted this cycle
lsu_wen  input  1  1=write, 0=read
lsu_addr  input  ADDR_WIDTH  LSU address
lsu_wdata  input  DATA_WIDTH  LSU write data
lsu_wmask  input  8  LSU byte write mask
lsu_resp_valid  output  1  one-cycle pulse: read data or write ack
lsu_rdata  output  DATA_WIDTH  LSU read data (0 on write ack)
mem_req_valid  output  1  request to memory
mem_req_ready  input  1  memory accepts request
mem_wen  output  1  write enable to memory
mem_addr  output  ADDR_WIDTH  memory address
mem_wdata  output  DATA_WIDTH  memory write data
mem_wmask  output  8  memory write mask
mem_resp_valid  input  1  memory response (read data or write done)
mem_rdata  input  DATA_WIDTH  memory read data
timeout_err  output  1  sticky: a response exceeded TIMEOUT

Behaviour:
- Reset: state=IDLE, last_grant=IFU, all outputs 0 (ready, valid, resp pulses, mem_* payload, rdata regs, timeout_err), counter=0. Reset mid-transaction abandons it with no response pulse; a late mem_resp_valid in IDLE is ignored.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant is combinational. Only one valid: that requester wins. Both valid: the one not equal to last_grant wins.
  - The winner's req_ready=1 (combinational, only in IDLE). The loser's req_ready=0.
  - On handshake, latch the payload into the mem_* registers, set last_grant=winner, and go to ISSUE. IFU payload: mem_wen=0, wdata=0, wmask=0.
  - No valid: stay in IDLE.
- ISSUE:
  - mem_req_valid=1 with a stable payload.
  - mem_req_ready=1: go to WAIT, mem_req_valid drops the next cycle.
  - mem_req_ready=0: hold all outputs.
- WAIT:
  - Counter increments each cycle.
  - mem_resp_valid=1: capture mem_rdata (forced to 0 if mem_wen) into the winner's rdata register and go to RESP. This takes priority over the timeout in the same cycle.
  - TIMEOUT!=0 and counter reaches TIMEOUT: set timeout_err=1 (sticky until rst) and keep waiting.
- RESP: the winner's resp_valid=1 for exactly this cycle, then go to IDLE and clear the counter. rdata holds until the next response to the same requester.
- Latency: with zero-wait memory (ready and resp both high), request acceptance to resp_valid is 3 cycles (IDLE→ISSUE→WAIT→RESP). Back-to-back throughput is one transaction per 4 cycles.
- mem_resp_valid outside WAIT is ignored. Requesters are never both ready in the same cycle.
- Requester inputs are sampled only at handshake; later changes do not affect the transaction in flight.

Test Plan:
- IFU only, ifu_raddr=0x80000000, memory ready/resp immediate with rdata=0x00000297 -> ifu_req_ready at cycle 0, mem_req_valid at cycle 1, ifu_resp_valid pulse at cycle 3 with ifu_rdata=0x00000297, lsu_resp_valid stays 0.
- LSU write addr=0x80001000, wdata=0xDEADBEEF, wmask=0x0F -> mem_wen=1 with matching mem_addr/mem_wdata/mem_wmask while mem_req_valid; lsu_resp_valid pulse with lsu_rdata=0.
- Both valid continuously for 4 transactions from reset -> grant order LSU, IFU, LSU, IFU; never both req_ready in the same cycle.
- mem_req_ready held low 5 cycles in ISSUE -> mem_req_valid and payload stable for all 5 cycles; response delivered after ready rises.
- TIMEOUT=4, mem_resp_valid withheld 10 cycles -> timeout_err=1 after 4 WAIT cycles and stays 1; the late response is still delivered to its requester.
- rst asserted in WAIT, then mem_resp_valid one cycle after rst deasserts -> no resp_valid pulse; all outputs 0; the next IFU request completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the IFU (read-only) and the LSU.
// One transaction in flight; payload is registered at grant and the response is steered back to the winner.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0] ifu_raddr,
    output logic                  ifu_resp_valid,
    output logic [DATA_WIDTH-1:0] ifu_rdata,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic                  lsu_wen,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    input  logic [7:0]            lsu_wmask,
    output logic                  lsu_resp_valid,
    output logic [DATA_WIDTH-1:0] lsu_rdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [7:0]            mem_wmask,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  timeout_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

    state_e                state_q, state_d;
    logic                  lastLsu_q, lastLsu_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  memWen_q, memWen_d;
    logic [ADDR_WIDTH-1:0] memAddr_q, memAddr_d;
    logic [DATA_WIDTH-1:0] memWdata_q, memWdata_d;
    logic [7:0]            memWmask_q, memWmask_d;
    logic [DATA_WIDTH-1:0] ifuRdata_q, ifuRdata_d;
    logic [DATA_WIDTH-1:0] lsuRdata_q, lsuRdata_d;
    logic                  timeoutErr_q, timeoutErr_d;
    logic                  grantLsu;
    logic                  anyValid;

    // When both request, the one that did not win last time goes first.
    assign grantLsu = lsu_req_valid && (!ifu_req_valid || !lastLsu_q);
    assign anyValid = ifu_req_valid || lsu_req_valid;

    assign ifu_req_ready  = (state_q == IDLE) && ifu_req_valid && !grantLsu;
    assign lsu_req_ready  = (state_q == IDLE) && grantLsu;
    assign mem_req_valid  = (state_q == ISSUE);
    assign ifu_resp_valid = (state_q == RESP) && !lastLsu_q;
    assign lsu_resp_valid = (state_q == RESP) && lastLsu_q;
    assign mem_wen        = memWen_q;
    assign mem_addr       = memAddr_q;
    assign mem_wdata      = memWdata_q;
    assign mem_wmask      = memWmask_q;
    assign ifu_rdata      = ifuRdata_q;
    assign lsu_rdata      = lsuRdata_q;
    assign timeout_err    = timeoutErr_q;

    always_comb begin
        state_d      = state_q;
        lastLsu_d    = lastLsu_q;
        cnt_d        = cnt_q;
        memWen_d     = memWen_q;
        memAddr_d    = memAddr_q;
        memWdata_d   = memWdata_q;
        memWmask_d   = memWmask_q;
        ifuRdata_d   = ifuRdata_q;
        lsuRdata_d   = lsuRdata_q;
        timeoutErr_d = timeoutErr_q;
        case (state_q)
            IDLE: begin
                if (anyValid) begin
                    lastLsu_d  = grantLsu;
                    memWen_d   = grantLsu && lsu_wen;
                    memAddr_d  = grantLsu ? lsu_addr : ifu_raddr;
                    memWdata_d = grantLsu ? lsu_wdata : '0;
                    memWmask_d = grantLsu ? lsu_wmask : '0;
                    cnt_d      = '0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    if (lastLsu_q) begin
                        lsuRdata_d = memWen_q ? '0 : mem_rdata;
                    end else begin
                        ifuRdata_d = mem_rdata;
                    end
                    state_d = RESP;
                end else if (TIMEOUT != 0 && cnt_q != TIMEOUT_CNT) begin
                    // Counter saturates at the limit so a very late response cannot wrap it.
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_d == TIMEOUT_CNT) begin
                        timeoutErr_d = 1'b1;
                    end
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            lastLsu_q    <= 1'b0;
            cnt_q        <= '0;
            memWen_q     <= 1'b0;
            memAddr_q    <= '0;
            memWdata_q   <= '0;
            memWmask_q   <= '0;
            ifuRdata_q   <= '0;
            lsuRdata_q   <= '0;
            timeoutErr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lastLsu_q    <= lastLsu_d;
            cnt_q        <= cnt_d;
            memWen_q     <= memWen_d;
            memAddr_q    <= memAddr_d;
            memWdata_q   <= memWdata_d;
            memWmask_q   <= memWmask_d;
            ifuRdata_q   <= ifuRdata_d;
            lsuRdata_q   <= lsuRdata_d;
            timeoutErr_q <= timeoutErr_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected memory payloads and responses,
// a memory model answers with configurable stalls, and a separate monitor checks every response pulse.
module tb_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifu_req_valid = 1'b0;
    logic        ifu_req_ready;
    logic [31:0] ifu_raddr = '0;
    logic        ifu_resp_valid;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid = 1'b0;
    logic        lsu_req_ready;
    logic        lsu_wen = 1'b0;
    logic [31:0] lsu_addr = '0;
    logic [31:0] lsu_wdata = '0;
    logic [7:0]  lsu_wmask = '0;
    logic        lsu_resp_valid;
    logic [31:0] lsu_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        timeout_err;

    typedef struct {
        bit          isLsu;
        logic [31:0] data;
        bit          checkLat;
        int          expCycle;
    } resp_t;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  wmask;
    } memreq_t;

    resp_t   respQ[$];
    memreq_t memQ[$];

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          issueStall = 0;
    int          respStall = 0;
    int          issueCnt = 0;
    int          waitCnt = 0;
    bit          waiting = 1'b0;
    bit          manual = 1'b0;
    bit          forceResp = 1'b0;
    bit          toCheck = 1'b0;
    logic [31:0] memData = '0;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_raddr(ifu_raddr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endfunction

    // Memory model: stalls ready for issueStall ISSUE cycles and response for respStall WAIT cycles,
    // and checks the presented payload against the expected request every cycle it is valid.
    always @(negedge clk) begin
        if (rst) begin
            waiting        = 1'b0;
            issueCnt       = 0;
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
        end else begin
            mem_resp_valid = 1'b0;
            if (mem_req_valid) begin
                if (memQ.size() == 0) begin
                    checkOutput("unexpected mem_req_valid", 64'(1), 64'(0));
                end else begin
                    checkOutput("mem_wen", 64'(mem_wen), 64'(memQ[0].wen));
                    checkOutput("mem_addr", 64'(mem_addr), 64'(memQ[0].addr));
                    checkOutput("mem_wdata", 64'(mem_wdata), 64'(memQ[0].wdata));
                    checkOutput("mem_wmask", 64'(mem_wmask), 64'(memQ[0].wmask));
                end
                if (issueCnt < issueStall) begin
                    mem_req_ready = 1'b0;
                    issueCnt++;
                end else begin
                    mem_req_ready = 1'b1;
                    issueCnt      = 0;
                    waiting       = 1'b1;
                    waitCnt       = 0;
                    if (memQ.size() > 0) void'(memQ.pop_front());
                end
            end else begin
                mem_req_ready = 1'b0;
                if (waiting) begin
                    if (toCheck) checkOutput("timeout_err in WAIT", 64'(timeout_err), 64'(waitCnt >= TO));
                    if (waitCnt >= respStall) begin
                        mem_resp_valid = 1'b1;
                        waiting        = 1'b0;
                    end else begin
                        waitCnt++;
                    end
                end
            end
            if (manual) mem_resp_valid = forceResp;
            mem_rdata = memData;
        end
    end

    // Response monitor: every resp pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        resp_t e;
        if (!rst && (ifu_resp_valid || lsu_resp_valid)) begin
            if (ifu_resp_valid && lsu_resp_valid) checkOutput("both resp_valid", 64'(1), 64'(0));
            if (respQ.size() == 0) begin
                checkOutput("unexpected resp_valid", 64'(1), 64'(0));
            end else begin
                e = respQ.pop_front();
                checkOutput("resp goes to lsu", 64'(lsu_resp_valid), 64'(e.isLsu));
                if (e.isLsu) checkOutput("lsu_rdata", 64'(lsu_rdata), 64'(e.data));
                else         checkOutput("ifu_rdata", 64'(ifu_rdata), 64'(e.data));
                if (e.checkLat) checkOutput("resp latency", 64'(cyc), 64'(e.expCycle));
            end
        end
    end

    task automatic doReset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Issues one request and waits for its handshake; expected payload and response are queued first.
    task automatic applyStimulus(input bit isLsu, input bit wen, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [7:0] wmask,
                                 input logic [31:0] rdata, input logic [31:0] expData, input bit checkLat);
        resp_t   r;
        memreq_t m;
        int      readyAt = -1;
        memData = rdata;
        m.wen   = isLsu ? wen : 1'b0;
        m.addr  = addr;
        m.wdata = isLsu ? wdata : 32'h0;
        m.wmask = isLsu ? wmask : 8'h0;
        memQ.push_back(m);
        r.isLsu = isLsu; r.data = expData; r.checkLat = checkLat; r.expCycle = 0;
        respQ.push_back(r);
        @(posedge clk); #1;
        if (isLsu) begin
            lsu_req_valid = 1'b1; lsu_wen = wen; lsu_addr = addr; lsu_wdata = wdata; lsu_wmask = wmask;
        end else begin
            ifu_req_valid = 1'b1; ifu_raddr = addr;
            lsu_wdata = 32'hA5A5A5A5; lsu_wmask = 8'hFF; lsu_wen = 1'b1;
        end
        for (int i = 0; i < 50 && readyAt < 0; i++) begin
            @(negedge clk);
            if (isLsu ? lsu_req_ready : ifu_req_ready) begin
                readyAt = i;
                respQ[respQ.size()-1].expCycle = cyc + 3;
                checkOutput("loser req_ready", 64'(isLsu ? ifu_req_ready : lsu_req_ready), 64'(0));
            end
        end
        if (readyAt < 0) checkOutput("req_ready never rose", 64'(0), 64'(1));
        else if (checkLat) checkOutput("req_ready cycle", 64'(readyAt), 64'(0));
        @(posedge clk); #1;
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        lsu_addr = ~addr; lsu_wdata = 32'h12345678; lsu_wmask = 8'hA5; lsu_wen = ~wen; ifu_raddr = ~addr;
    endtask

    task automatic drain();
        int n = 0;
        while (respQ.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (respQ.size() > 0) begin
            checkOutput("response never arrived", 64'(0), 64'(1));
            respQ.delete();
            memQ.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        memreq_t m;
        resp_t   r;
        int      ifuN = 0;
        int      lsuN = 0;

        doReset();
        @(negedge clk);
        checkOutput("reset mem_req_valid", 64'(mem_req_valid), 64'(0));
        checkOutput("reset ifu_resp_valid", 64'(ifu_resp_valid), 64'(0));
        checkOutput("reset lsu_resp_valid", 64'(lsu_resp_valid), 64'(0));
        checkOutput("reset ifu_rdata", 64'(ifu_rdata), 64'(0));
        checkOutput("reset lsu_rdata", 64'(lsu_rdata), 64'(0));
        checkOutput("reset mem_addr", 64'(mem_addr), 64'(0));
        checkOutput("reset mem_wdata", 64'(mem_wdata), 64'(0));
        checkOutput("reset mem_wmask", 64'(mem_wmask), 64'(0));
        checkOutput("reset mem_wen", 64'(mem_wen), 64'(0));
        checkOutput("reset timeout_err", 64'(timeout_err), 64'(0));

        // IFU fetch with zero-wait memory, then an LSU write
        applyStimulus(1'b0, 1'b0, 32'h80000000, 32'h0, 8'h0, 32'h00000297, 32'h00000297, 1'b1);
        drain();
        applyStimulus(1'b1, 1'b1, 32'h80001000, 32'hDEADBEEF, 8'h0F, 32'h11111111, 32'h0, 1'b1);
        drain();
        checkOutput("ifu_rdata held", 64'(ifu_rdata), 64'(32'h00000297));
        applyStimulus(1'b1, 1'b0, 32'h80001004, 32'h0, 8'h0, 32'h0BADF00D, 32'h0BADF00D, 1'b1);
        drain();

        // Both requesters valid from reset: LSU, IFU, LSU, IFU
        doReset();
        memData = 32'hCAFEF00D;
        for (int k = 0; k < 4; k++) begin
            m.wen   = 1'b0;
            m.addr  = (k % 2 == 0) ? 32'h80002000 : 32'h80000040;
            m.wdata = 32'h0;
            m.wmask = 8'h0;
            memQ.push_back(m);
            r.isLsu = (k % 2 == 0); r.data = 32'hCAFEF00D; r.checkLat = 1'b0; r.expCycle = 0;
            respQ.push_back(r);
        end
        ifu_raddr = 32'h80000040;
        lsu_addr = 32'h80002000; lsu_wen = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 8'h0;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        for (int i = 0; i < 60 && (ifu_req_valid || lsu_req_valid); i++) begin
            @(negedge clk);
            checkOutput("both req_ready", 64'(ifu_req_ready && lsu_req_ready), 64'(0));
            if (ifu_req_ready) ifuN++;
            if (lsu_req_ready) lsuN++;
            @(posedge clk); #1;
            if (ifuN == 2) ifu_req_valid = 1'b0;
            if (lsuN == 2) lsu_req_valid = 1'b0;
        end
        checkOutput("round-robin grants done", 64'(ifu_req_valid || lsu_req_valid), 64'(0));
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        drain();

        // Memory holds off ready for 5 ISSUE cycles
        issueStall = 5;
        applyStimulus(1'b1, 1'b0, 32'h80003008, 32'h0, 8'h0, 32'h55AA1234, 32'h55AA1234, 1'b0);
        drain();
        issueStall = 0;

        // Response withheld 10 WAIT cycles trips the timeout flag
        checkOutput("timeout_err before", 64'(timeout_err), 64'(0));
        toCheck = 1'b1;
        respStall = 10;
        applyStimulus(1'b0, 1'b0, 32'h80000100, 32'h0, 8'h0, 32'h00100073, 32'h00100073, 1'b0);
        drain();
        toCheck = 1'b0;
        respStall = 0;
        checkOutput("timeout_err sticky", 64'(timeout_err), 64'(1));

        // Reset while in WAIT, then a late response lands in IDLE
        respStall = 100;
        applyStimulus(1'b0, 1'b0, 32'h80000200, 32'h0, 8'h0, 32'hFEEDFACE, 32'hFEEDFACE, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        manual = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        forceResp = 1'b1;
        respQ.delete();
        memQ.delete();
        @(posedge clk); #1;
        forceResp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("post-reset resp pulses", 64'(ifu_resp_valid || lsu_resp_valid), 64'(0));
            checkOutput("post-reset mem_req_valid", 64'(mem_req_valid), 64'(0));
            checkOutput("post-reset timeout_err", 64'(timeout_err), 64'(0));
            checkOutput("post-reset ifu_rdata", 64'(ifu_rdata), 64'(0));
            checkOutput("post-reset lsu_rdata", 64'(lsu_rdata), 64'(0));
            checkOutput("post-reset mem_addr", 64'(mem_addr), 64'(0));
        end
        manual = 1'b0;
        respStall = 0;
        applyStimulus(1'b0, 1'b0, 32'h80000204, 32'h0, 8'h0, 32'h00008067, 32'h00008067, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
